// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch/prefetch stage: issues sequential word fetches, buffers
// returned words with their PC in an in-order FIFO, and flushes on redirect.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   rsp_pc, rsp_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop_cnt, drop_cnt_nxt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        fifo [DEPTH];
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_base;
  logic          credit, req_hs, push, pop;

  assign redirect_base = redirect_pc & ~32'd3;
  assign occupancy     = {1'b0, count} + {1'b0, outstanding};
  assign credit        = occupancy < (CW+1)'(DEPTH);

  // Request is gated during reset and on a redirect cycle so the memory never
  // accepts a fetch that this block would not count.
  assign mem_req_valid = reset && !redirect && (state == FETCH) && credit;
  assign mem_req_addr  = fetch_pc;
  assign req_hs        = mem_req_valid && mem_req_ready;

  assign push        = mem_rsp_valid && !redirect && (state == FETCH);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = fifo[rd_ptr].data;
  assign instr_pc    = fifo[rd_ptr].pc;

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    if (redirect) begin
      // A response arriving with the redirect is already stale and is dropped.
      fetch_pc_nxt    = redirect_base;
      rsp_pc_nxt      = redirect_base;
      outstanding_nxt = outstanding - CW'(mem_rsp_valid);
      drop_cnt_nxt    = outstanding_nxt;
      state_nxt       = (outstanding_nxt == '0) ? FETCH : DRAIN;
    end else begin
      if (req_hs) fetch_pc_nxt = fetch_pc + 32'd4;
      if (push)   rsp_pc_nxt   = rsp_pc + 32'd4;
      outstanding_nxt = outstanding + CW'(req_hs) - CW'(mem_rsp_valid);
      if (state == DRAIN && mem_rsp_valid) begin
        drop_cnt_nxt = drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // Credit keeps count+outstanding <= DEPTH, so a push always has room even
  // when it coincides with a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{data: mem_rsp_data, pc: rsp_pc};
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
